// File: rtl/mem_load_unit_if.sv
// mem_load_unit_if: bundles the load-request handshake, the dmem read port
// and the load response of mem_load_unit.
//   req_valid/req_ready/addr/func3 : one load request from the MEM stage
//   mem_re/mem_addr/mem_rdata      : synchronous dmem read (data one cycle later)
//   resp_valid/resp_data           : single-cycle response pulse, no backpressure
//   load_misaligned                : trap flag, qualified by resp_valid
// Modports: slave = the load unit, master = MEM stage plus the memory.
interface mem_load_unit_if #(
  parameter int MEM_AW = 13,
  parameter int XLEN   = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       addr;
  logic [2:0]        func3;
  logic              mem_re;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_rdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_data;
  logic              load_misaligned;

  modport slave (
    input  req_valid, addr, func3, mem_rdata,
    output req_ready, mem_re, mem_addr, resp_valid, resp_data, load_misaligned
  );

  modport master (
    output req_valid, addr, func3, mem_rdata,
    input  req_ready, mem_re, mem_addr, resp_valid, resp_data, load_misaligned
  );
endinterface

// File: rtl/mem_load_unit.sv
// mem_load_unit: read side of the data-memory path. Takes one load request
// (byte address + RISC-V load func3), reads one or two 64-bit dmem words,
// extracts the addressed byte/half/word/double and sign- or zero-extends it.
// Loads straddling a word boundary are read as two beats and merged.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mem_load_unit_if.slave (request, dmem read port, response)
// Optional feature macro MISALIGN_TRAP_EN: misaligned loads skip the memory,
// respond one cycle after accept with resp_data=0 and load_misaligned=1.
// Without it misaligned loads are split/merged and load_misaligned is 0.
module mem_load_unit #(
  parameter int MEM_AW = 13,
  parameter int XLEN   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_load_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state;
  logic [2:0]        off_q;
  logic [2:0]        f3_q;
  logic              cross_q;
  logic [MEM_AW-1:0] waddr_q;
  logic [XLEN-1:0]   lo_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              mis_q;

  // Request decode (valid only while IDLE)
  logic [3:0] req_size;
  logic       req_cross;
  logic       req_mis;
  logic       accept;

  assign req_size  = 4'd1 << bus.func3[1:0];
  // Reserved func3 is always a single beat, regardless of offset
  assign req_cross = (bus.func3 != 3'b111) &&
                     (({1'b0, bus.addr[2:0]} + req_size) > 4'd8);
`ifdef MISALIGN_TRAP_EN
  // size-1 as a low-bit mask; for ld size[2:0]=0 so the mask becomes 3'b111
  assign req_mis = (bus.func3 != 3'b111) &&
                   ((bus.addr[2:0] & (req_size[2:0] - 3'd1)) != 3'd0);
`else
  assign req_mis = 1'b0;
`endif
  assign accept = (state == IDLE) && bus.req_valid;

  // First read is issued combinationally in the accept cycle; the second
  // beat reads the following word (wrapping modulo the dmem size).
  assign bus.req_ready = (state == IDLE);
  assign bus.mem_re    = (accept && !req_mis) || ((state == BEAT0) && cross_q);
  assign bus.mem_addr  = (state == IDLE) ? bus.addr[MEM_AW+2:3]
                                         : waddr_q + MEM_AW'(1);

  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_data       = resp_data_q;
  assign bus.load_misaligned = mis_q;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[63:MEM_AW+3];

  // Merge: the beat arriving this cycle comes straight from mem_rdata, the
  // earlier low beat from lo_q. hi is zero for single-beat loads.
  logic [XLEN-1:0] lo_in;
  logic [XLEN-1:0] hi_in;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext;

  assign lo_in   = (state == BEAT0) ? bus.mem_rdata : lo_q;
  assign hi_in   = (state == BEAT1) ? bus.mem_rdata : '0;
  assign shifted = XLEN'({hi_in, lo_in} >> {off_q, 3'b000});

  always_comb begin
    ext = '0;
    case (f3_q)
      3'b000:  ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  ext = shifted;
      3'b100:  ext = {56'd0, shifted[7:0]};
      3'b101:  ext = {48'd0, shifted[15:0]};
      3'b110:  ext = {32'd0, shifted[31:0]};
      default: ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      off_q        <= '0;
      f3_q         <= '0;
      cross_q      <= 1'b0;
      waddr_q      <= '0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mis_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            off_q   <= bus.addr[2:0];
            f3_q    <= bus.func3;
            cross_q <= req_cross;
            waddr_q <= bus.addr[MEM_AW+2:3];
            if (req_mis) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
              mis_q        <= 1'b1;
            end else begin
              state <= BEAT0;
            end
          end
        end
        BEAT0: begin
          lo_q <= bus.mem_rdata;
          if (cross_q) begin
            state <= BEAT1;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= ext;
            mis_q        <= 1'b0;
          end
        end
        BEAT1: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_data_q  <= ext;
          mis_q        <= 1'b0;
        end
        default: begin
          // RESP: the pulse lasts exactly this cycle; data is held afterwards
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          mis_q        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Testbench for mem_load_unit: directed vector table, a reset-during-load
// sequence and randomized loads checked against a byte-level memory model.
module tb_mem_load_unit;
  localparam int MEM_AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_load_unit_if #(.MEM_AW(MEM_AW), .XLEN(64)) bus();

  mem_load_unit #(.MEM_AW(MEM_AW), .XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Synchronous dmem model
  logic [63:0] mem [0:(1<<MEM_AW)-1];
  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [63:0] b);
    logic [MEM_AW-1:0] w;
    logic [63:0] word;
    w = b[MEM_AW+2:3];
    word = mem[w] >> (8 * int'(b[2:0]));
    return word[7:0];
  endfunction

  // Reference: assemble the load byte by byte from the memory image
  function automatic void model(input logic [63:0] a, input logic [2:0] f3,
                                output logic [63:0] d, output int lat);
    int sz;
    int off;
    logic [63:0] v;
    sz  = 1 << f3[1:0];
    off = int'(a[2:0]);
    v   = '0;
    if (f3 == 3'b111) begin d = '0; lat = 2; return; end
`ifdef MISALIGN_TRAP_EN
    if (off % sz != 0) begin d = '0; lat = 1; return; end
`endif
    for (int i = 0; i < sz; i++) v |= 64'(byte_at(a + 64'(i))) << (8 * i);
    if (sz < 8 && !f3[2] && v[8*sz-1]) v |= ~64'd0 << (8 * sz);
    d   = v;
    lat = (off + sz > 8) ? 3 : 2;
  endfunction

  // One load: latency 1 = trap (no reads), 2 = one read, 3 = two reads
  task automatic do_load(input string tag, input logic [63:0] a, input logic [2:0] f3,
                         input logic [63:0] exp_d, input int exp_lat);
    int first, nresp, nre, exp_reads;
    logic [63:0] a2, d_at;
    logic mis_at;
    logic [MEM_AW-1:0] exp_a1, exp_a2;
    first = -1; nresp = 0; nre = 0; a2 = '0; d_at = '0; mis_at = 1'b0;
    exp_reads = exp_lat - 1;
    exp_a1 = a[MEM_AW+2:3];
    exp_a2 = MEM_AW'((a >> 3) + 64'd1);
    @(negedge clk);
    chk({tag, " ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.addr = a; bus.func3 = f3;
    #1;
    chk({tag, " re_T"}, 64'(bus.mem_re), 64'(exp_reads > 0));
    if (exp_reads > 0) chk({tag, " addr_T"}, 64'(bus.mem_addr), 64'(exp_a1));
    nre = int'(bus.mem_re);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus.mem_re) begin nre++; if (k == 1) a2 = 64'(bus.mem_addr); end
      if (bus.resp_valid) begin
        nresp++;
        if (first < 0) begin first = k; d_at = bus.resp_data; mis_at = bus.load_misaligned; end
      end
    end
    chk({tag, " latency"}, 64'(first), 64'(exp_lat));
    chk({tag, " pulses"}, 64'(nresp), 64'd1);
    chk({tag, " data"}, d_at, exp_d);
    chk({tag, " misaligned"}, 64'(mis_at), 64'(exp_lat == 1));
    chk({tag, " reads"}, 64'(nre), 64'(exp_reads));
    if (exp_reads == 2) chk({tag, " addr_2"}, a2, 64'(exp_a2));
    chk({tag, " hold"}, bus.resp_data, exp_d);
  endtask

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [2:0]  f3;
    logic [63:0] d;
    int          lat;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [63:0] ra, rd;
    logic [2:0] rf;
    int rl, nresp;

    bus.req_valid = 1'b0; bus.addr = '0; bus.func3 = '0;
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = {$urandom, $urandom};
    mem[2]     = 64'h8877_6655_4433_2211;
    mem[3]     = 64'h0000_0000_0000_00AA;
    mem[13'h1FFF] = 64'h0123_4567_89AB_CDEF;
    mem[0]     = 64'h1111_1111_1111_115A;

    tbl.push_back('{"lb17",  64'h17, 3'b000, 64'hFFFF_FFFF_FFFF_FF88, 2});
    tbl.push_back('{"lbu17", 64'h17, 3'b100, 64'h0000_0000_0000_0088, 2});
    tbl.push_back('{"lwu14", 64'h14, 3'b110, 64'h0000_0000_8877_6655, 2});
    tbl.push_back('{"lw14",  64'h14, 3'b010, 64'hFFFF_FFFF_8877_6655, 2});
    tbl.push_back('{"ld10",  64'h10, 3'b011, 64'h8877_6655_4433_2211, 2});
    tbl.push_back('{"rsv13", 64'h13, 3'b111, 64'h0, 2});
    tbl.push_back('{"lh12",  64'h12, 3'b001, 64'h0000_0000_0000_4433, 2});
    tbl.push_back('{"lh16",  64'h16, 3'b001, 64'hFFFF_FFFF_FFFF_8877, 2});
    tbl.push_back('{"lhu16", 64'h16, 3'b101, 64'h0000_0000_0000_8877, 2});
`ifdef MISALIGN_TRAP_EN
    tbl.push_back('{"lw16x",   64'h16,   3'b010, 64'h0, 1});
    tbl.push_back('{"ldwrap",  64'hFFF9, 3'b011, 64'h0, 1});
    tbl.push_back('{"lh11",    64'h11,   3'b001, 64'h0, 1});
`else
    tbl.push_back('{"lw16x",   64'h16,   3'b010, 64'h0000_0000_00AA_8877, 3});
    tbl.push_back('{"ldwrap",  64'hFFF9, 3'b011, 64'h5A01_2345_6789_ABCD, 3});
    tbl.push_back('{"lh11",    64'h11,   3'b001, 64'h0000_0000_0000_3322, 2});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst mem_re", 64'(bus.mem_re), 64'd0);
    chk("rst resp_data", bus.resp_data, 64'd0);
    chk("rst misaligned", 64'(bus.load_misaligned), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", 64'(bus.req_ready), 64'd1);

    foreach (tbl[i]) do_load(tbl[i].name, tbl[i].a, tbl[i].f3, tbl[i].d, tbl[i].lat);

    // Reset in the middle of a load: no response may appear
    @(negedge clk);
    bus.req_valid = 1'b1;
`ifdef MISALIGN_TRAP_EN
    bus.addr = 64'h10; bus.func3 = 3'b011;
`else
    bus.addr = 64'h16; bus.func3 = 3'b010;
`endif
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
`ifndef MISALIGN_TRAP_EN
    @(negedge clk);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    nresp = 0;
    @(negedge clk);
    chk("midrst ready", 64'(bus.req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid) nresp++;
      @(negedge clk);
    end
    chk("midrst no_resp", 64'(nresp), 64'd0);
    do_load("post_rst_lb", 64'h17, 3'b000, 64'hFFFF_FFFF_FFFF_FF88, 2);

    // Randomized loads against the byte-level model
    for (int n = 0; n < 200; n++) begin
      ra = {$urandom, $urandom};
      rf = 3'($urandom_range(0, 7));
      model(ra, rf, rd, rl);
      do_load($sformatf("rnd%0d", n), ra, rf, rd, rl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Read-side counterpart to the dmem store path.
- Accepts one load request (byte address, func3) from the MEM stage and issues 64-bit word reads to the synchronous data memory.
- Extracts the addressed byte, half, word or double, then sign- or zero-extends it to 64 bits.
- Loads that cross a 64-bit word boundary are split into two word reads and merged; the result returns as a single-cycle response pulse.

Parameters:
- MEM_AW, 13, dmem word-address width; mem_addr = addr[MEM_AW+2:3].
- XLEN, 64, data width. Fixed at 64; other values are unsupported.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request. High only in IDLE.
- addr  input  64  byte address of the load.
- func3  input  3  RISC-V load func3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 reserved.
- mem_re  output  1  dmem read strobe.
- mem_addr  output  MEM_AW  dmem word address.
- mem_rdata  input  64  dmem read data, valid the cycle after mem_re.
- resp_valid  output  1  one-cycle pulse; resp_data is valid.
- resp_data  output  64  extended load result.
- load_misaligned  output  1  qualified by resp_valid. Meaningful only with MISALIGN_TRAP_EN; otherwise tied 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; resp_valid=0; resp_data=0; mem_re=0; load_misaligned=0.
  - Internal offset, func3 and low-beat registers are cleared.
  - Reset mid-operation abandons the load with no response.
- Size and crossing rules:
  - size = 1/2/4/8 bytes for func3[1:0] = 00/01/10/11.
  - off = addr[2:0].
  - The load crosses a word boundary when off+size > 8.
- State machine: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid (cycle T): mem_re=1 and mem_addr=addr[MEM_AW+2:3], both combinational from addr.
  - Latch off, func3, cross and word address; go to BEAT0.
- BEAT0 (T+1):
  - Capture mem_rdata into lo.
  - If cross: drive mem_re=1 and mem_addr=latched+1, modulo 2^MEM_AW so 0x1FFF wraps to 0x0000; go to BEAT1.
  - Else: go to RESP.
- BEAT1 (T+2): capture mem_rdata into hi; go to RESP.
- RESP:
  - Registered output: resp_valid=1 for exactly one cycle; state returns to IDLE.
  - Latency: non-crossing loads have resp_valid at T+2; crossing loads at T+3.
- Merge and extract:
  - raw = ({hi,lo} >> (off*8))[size*8-1:0]. hi is 0 for non-crossing loads.
  - func3[2]=0: sign-extend from bit size*8-1.
  - func3[2]=1: zero-extend.
  - func3=111: single beat, resp_data=0, no error.
- Outputs outside RESP: mem_re=0 except as stated above. resp_data holds its last value when resp_valid=0.
- req_ready=0 in BEAT0, BEAT1 and RESP. req_valid is ignored in those states, so there is no back-to-back accept; the next accept can occur in the cycle after RESP.
- No response backpressure: the consumer must take resp_data on the pulse.
- addr bits above MEM_AW+2 are ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Any load with off not a multiple of size (lh at odd off, lw at off%4≠0, ld at off≠0) issues no memory read; mem_re=0 at T.
  - Goes directly to RESP: resp_valid at T+1, resp_data=0, load_misaligned=1.
  - Aligned loads are unchanged, with load_misaligned=0.
  - The BEAT1 path is unreachable.
- Undefined: misaligned loads are split and merged as above; load_misaligned is constant 0.

Test Plan:
- Byte loads: mem word at 0x010 = 0x8877_6655_4433_2211; lb at addr 0x017.
  - mem_addr=0x002 at T.
  - resp_valid at T+2, resp_data=0xFFFF_FFFF_FFFF_FF88.
  - Repeat with lbu at 0x017: resp_data=0x0000_0000_0000_0088.
- Aligned word loads, same word:
  - lwu at 0x014: 0x0000_0000_8877_6655.
  - lw at 0x014: 0xFFFF_FFFF_8877_6655.
  - ld at 0x010: 0x8877_6655_4433_2211.
  - Each has 2-cycle latency with mem_re high for one cycle.
- Crossing lw at 0x016 (macro off), word 2 = 0x8877_6655_4433_2211, word 3 = 0x0000_0000_0000_00AA:
  - mem_addr 0x002 then 0x003 on consecutive cycles.
  - resp at T+3, resp_data=0x0000_0000_00AA_8877.
- Wrap: ld at 0xFFF9 (macro off).
  - Word reads at 0x1FFF then 0x0000.
  - Result is merged bytes 1..7 of word 0x1FFF and byte 0 of word 0x0000.
- Reset mid-operation: assert rst_n=0 during BEAT1.
  - No resp_valid is produced.
  - req_ready=1 the cycle after reset deasserts.
  - The next lb returns the correct data.
- MISALIGN_TRAP_EN defined: lh at 0x011.
  - mem_re never asserts.
  - resp_valid at T+1 with load_misaligned=1 and resp_data=0.
  - lh at 0x012 returns normally with load_misaligned=0.
